// File: rtl/fetch_ifid_ctrl_if.sv
// Fetch-stage bus bundle: hazard/redirect inputs, instruction memory port, IF/ID outputs and status.
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_ifid_ctrl_if #(
    parameter int XLEN = 32
);
    logic            pc_hold;
    logic            ifid_hold;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic [31:0]     imem_rdata;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] ifid_pc;
    logic [31:0]     ifid_instr;
    logic            ifid_valid;
    logic            stall_active;
    logic            flush_active;
    logic            misalign_err;
    logic            stall_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     perf_stall_cycles;
    logic [31:0]     perf_flushes;

    modport master (
        input  pc_hold, ifid_hold, branch_taken, branch_target, imem_rdata,
        output imem_addr, ifid_pc, ifid_instr, ifid_valid,
        output stall_active, flush_active, misalign_err, stall_err,
        output perf_stall_cycles, perf_flushes
    );

    modport slave (
        output pc_hold, ifid_hold, branch_taken, branch_target, imem_rdata,
        input  imem_addr, ifid_pc, ifid_instr, ifid_valid,
        input  stall_active, flush_active, misalign_err, stall_err,
        input  perf_stall_cycles, perf_flushes
    );
`else
    modport master (
        input  pc_hold, ifid_hold, branch_taken, branch_target, imem_rdata,
        output imem_addr, ifid_pc, ifid_instr, ifid_valid,
        output stall_active, flush_active, misalign_err, stall_err
    );

    modport slave (
        output pc_hold, ifid_hold, branch_taken, branch_target, imem_rdata,
        input  imem_addr, ifid_pc, ifid_instr, ifid_valid,
        input  stall_active, flush_active, misalign_err, stall_err
    );
`endif
endinterface

// File: rtl/fetch_ifid_ctrl.sv
// Fetch-stage controller: PC register, IF/ID pipeline register, hold/flush handling.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_ifid_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
    parameter int              MAX_STALL = 2
) (
    input logic             clk,
    input logic             rst_n,
    fetch_ifid_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(MAX_STALL);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] ifid_pc_q;
    logic [31:0]     ifid_instr_q;
    logic            ifid_valid_q;
    logic            misalign_q;
    logic            stall_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic            hold;
    logic            hold_cycle;

    assign hold       = bus.pc_hold | bus.ifid_hold;
    assign hold_cycle = hold & ~bus.branch_taken;
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    assign bus.imem_addr    = pc_q;
    assign bus.ifid_pc      = ifid_pc_q;
    assign bus.ifid_instr   = ifid_instr_q;
    assign bus.ifid_valid   = ifid_valid_q;
    assign bus.misalign_err = misalign_q;
    assign bus.stall_err    = stall_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.stall_active = (state_q == STALL);
        bus.flush_active = (state_q == FLUSH);
        if (bus.branch_taken) begin
            state_d = FLUSH;
        end else if (hold) begin
            state_d = STALL;
        end else begin
            state_d = RUN;
        end
    end

    // Redirect beats any hold; an IF/ID hold also freezes the PC so no fetch is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            misalign_q <= bus.branch_taken & (bus.branch_target[1:0] != 2'b00);
            if (bus.branch_taken) begin
                pc_q         <= {bus.branch_target[XLEN-1:2], 2'b00};
                ifid_pc_q    <= '0;
                ifid_instr_q <= NOP_INSTR;
                ifid_valid_q <= 1'b0;
            end else if (bus.ifid_hold) begin
                pc_q         <= pc_q;
            end else if (bus.pc_hold) begin
                ifid_pc_q    <= '0;
                ifid_instr_q <= NOP_INSTR;
                ifid_valid_q <= 1'b0;
            end else begin
                pc_q         <= pc_q + XLEN'(4);
                ifid_pc_q    <= pc_q;
                ifid_instr_q <= bus.imem_rdata;
                ifid_valid_q <= 1'b1;
            end
        end
    end

    // The error flags on the edge that makes the hold run exceed MAX_STALL cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            stall_err_q <= 1'b0;
        end else begin
            cnt_q <= hold_cycle ? cnt_inc : '0;
            if (hold_cycle && (cnt_inc > STALL_LIMIT)) begin
                stall_err_q <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    assign bus.perf_stall_cycles = perf_stall_q;
    assign bus.perf_flushes      = perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (hold_cycle) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (bus.branch_taken) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ifid_ctrl.sv
// Self-checking bench for fetch_ifid_ctrl: a reference model pushes expected IF/ID state
// to a scoreboard each cycle; the entry is popped and compared after the clock edge.
module tb_fetch_ifid_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fetch_ifid_ctrl_if #(.XLEN(32)) bus();

    fetch_ifid_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_rdata = 32'h00A00093 + bus.imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifid_pc;
        logic [31:0] instr;
        logic        valid;
        logic        st;
        logic        fl;
        logic        mis;
        logic        serr;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc, m_ifid_pc, m_instr, m_ps, m_pf;
    logic        m_valid, m_st, m_fl, m_mis, m_serr;
    int          m_cnt;

    task automatic model_reset();
        m_pc = 32'h0; m_ifid_pc = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
        m_st = 1'b0; m_fl = 1'b0; m_mis = 1'b0; m_serr = 1'b0; m_cnt = 0;
        m_ps = 32'h0; m_pf = 32'h0;
    endtask

    // One clock: drive inputs, predict the post-edge state, then compare after the edge.
    task automatic step(input logic ph, input logic ih, input logic bt, input logic [31:0] tgt);
        exp_t e;
        logic hold;
        bus.pc_hold = ph; bus.ifid_hold = ih; bus.branch_taken = bt; bus.branch_target = tgt;
        hold  = ph | ih;
        m_mis = bt && (tgt[1:0] != 2'b00);
        if (hold && !bt) begin
            m_cnt = (m_cnt == 3) ? 3 : m_cnt + 1;
            if (m_cnt > 2) m_serr = 1'b1;
            m_ps = m_ps + 1;
        end else begin
            m_cnt = 0;
        end
        if (bt) m_pf = m_pf + 1;
        m_st = !bt && hold;
        m_fl = bt;
        if (bt) begin
            m_pc = {tgt[31:2], 2'b00}; m_ifid_pc = 0; m_instr = 32'h13; m_valid = 1'b0;
        end else if (ih) begin
        end else if (ph) begin
            m_ifid_pc = 0; m_instr = 32'h13; m_valid = 1'b0;
        end else begin
            m_instr = 32'h00A00093 + m_pc; m_ifid_pc = m_pc; m_valid = 1'b1; m_pc = m_pc + 4;
        end
        e = '{m_pc, m_ifid_pc, m_instr, m_valid, m_st, m_fl, m_mis, m_serr, m_ps, m_pf};
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        total++; if (bus.imem_addr !== e.pc) begin bad++; $display("[TB] FAIL sb_pc: got %h expected %h", bus.imem_addr, e.pc); end
        total++; if (bus.ifid_pc !== e.ifid_pc) begin bad++; $display("[TB] FAIL sb_ifid_pc: got %h expected %h", bus.ifid_pc, e.ifid_pc); end
        total++; if (bus.ifid_instr !== e.instr) begin bad++; $display("[TB] FAIL sb_instr: got %h expected %h", bus.ifid_instr, e.instr); end
        total++; if (bus.ifid_valid !== e.valid) begin bad++; $display("[TB] FAIL sb_valid: got %b expected %b", bus.ifid_valid, e.valid); end
        total++; if (bus.stall_active !== e.st) begin bad++; $display("[TB] FAIL sb_stall_active: got %b expected %b", bus.stall_active, e.st); end
        total++; if (bus.flush_active !== e.fl) begin bad++; $display("[TB] FAIL sb_flush_active: got %b expected %b", bus.flush_active, e.fl); end
        total++; if (bus.misalign_err !== e.mis) begin bad++; $display("[TB] FAIL sb_misalign: got %b expected %b", bus.misalign_err, e.mis); end
        total++; if (bus.stall_err !== e.serr) begin bad++; $display("[TB] FAIL sb_stall_err: got %b expected %b", bus.stall_err, e.serr); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (bus.perf_stall_cycles !== e.ps) begin bad++; $display("[TB] FAIL sb_perf_stall: got %0d expected %0d", bus.perf_stall_cycles, e.ps); end
        total++; if (bus.perf_flushes !== e.pf) begin bad++; $display("[TB] FAIL sb_perf_flush: got %0d expected %0d", bus.perf_flushes, e.pf); end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pc_hold = 0; bus.ifid_hold = 0; bus.branch_taken = 0; bus.branch_target = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h expected 0", bus.imem_addr); end
        total++; if (bus.ifid_instr !== 32'h13) begin bad++; $display("[TB] FAIL reset_instr: got %h expected 00000013", bus.ifid_instr); end
        total++; if (bus.ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.ifid_valid); end
        total++; if ({bus.stall_active, bus.flush_active, bus.misalign_err, bus.stall_err} !== 4'b0) begin
            bad++; $display("[TB] FAIL reset_status: got %b expected 0000", {bus.stall_active, bus.flush_active, bus.misalign_err, bus.stall_err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [31:0] want_addr [4];
        want_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 2; i++) begin
            total++; if (bus.imem_addr !== want_addr[i]) begin bad++; $display("[TB] FAIL run_addr%0d: got %h expected %h", i, bus.imem_addr, want_addr[i]); end
            step(0, 0, 0, 0);
        end
        total++; if (bus.ifid_valid !== 1'b1) begin bad++; $display("[TB] FAIL run_valid: got %b expected 1", bus.ifid_valid); end
        // Load-use hold at pc=8
        step(1, 1, 0, 0);
        total++; if (bus.imem_addr !== want_addr[2]) begin bad++; $display("[TB] FAIL hold_addr: got %h expected %h", bus.imem_addr, want_addr[2]); end
        total++; if (bus.ifid_pc !== 32'h4) begin bad++; $display("[TB] FAIL hold_ifid_pc: got %h expected 4", bus.ifid_pc); end
        total++; if (bus.stall_active !== 1'b1) begin bad++; $display("[TB] FAIL hold_stall_active: got %b expected 1", bus.stall_active); end
        step(0, 0, 0, 0);
        total++; if (bus.imem_addr !== want_addr[3]) begin bad++; $display("[TB] FAIL after_hold_addr: got %h expected %h", bus.imem_addr, want_addr[3]); end
        total++; if (bus.stall_err !== 1'b0) begin bad++; $display("[TB] FAIL after_hold_serr: got %b expected 0", bus.stall_err); end
    endtask

    task automatic test_bubble();
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        total++; if (bus.ifid_instr !== 32'h00000013) begin bad++; $display("[TB] FAIL bubble_instr: got %h expected 00000013", bus.ifid_instr); end
        total++; if (bus.imem_addr !== 32'h10) begin bad++; $display("[TB] FAIL bubble_pc: got %h expected 10", bus.imem_addr); end
        step(0, 0, 0, 0);
        total++; if (bus.ifid_pc !== 32'h10) begin bad++; $display("[TB] FAIL bubble_resume: got %h expected 10", bus.ifid_pc); end
    endtask

    task automatic test_branch_flush();
        step(1, 0, 1, 32'h100);
        total++; if (bus.imem_addr !== 32'h100) begin bad++; $display("[TB] FAIL br_pc: got %h expected 100", bus.imem_addr); end
        total++; if (bus.flush_active !== 1'b1) begin bad++; $display("[TB] FAIL br_flush: got %b expected 1", bus.flush_active); end
        step(0, 0, 0, 0);
        total++; if (bus.ifid_pc !== 32'h100) begin bad++; $display("[TB] FAIL br_ifid_pc: got %h expected 100", bus.ifid_pc); end
        total++; if (bus.flush_active !== 1'b0) begin bad++; $display("[TB] FAIL br_flush_end: got %b expected 0", bus.flush_active); end
    endtask

    task automatic test_misalign_stall_err();
        step(0, 0, 1, 32'h102);
        total++; if (bus.misalign_err !== 1'b1) begin bad++; $display("[TB] FAIL mis_pulse: got %b expected 1", bus.misalign_err); end
        total++; if (bus.imem_addr !== 32'h100) begin bad++; $display("[TB] FAIL mis_pc: got %h expected 100", bus.imem_addr); end
        step(0, 0, 0, 0);
        total++; if (bus.misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL mis_clear: got %b expected 0", bus.misalign_err); end
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        total++; if (bus.stall_err !== 1'b0) begin bad++; $display("[TB] FAIL serr_early: got %b expected 0", bus.stall_err); end
        step(1, 1, 0, 0);
        total++; if (bus.stall_err !== 1'b1) begin bad++; $display("[TB] FAIL serr_set: got %b expected 1", bus.stall_err); end
        repeat (2) step(0, 0, 0, 0);
        total++; if (bus.stall_err !== 1'b1) begin bad++; $display("[TB] FAIL serr_sticky: got %b expected 1", bus.stall_err); end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 1, 32'h200);
        step(1, 1, 1, 32'h300);
        total++; if (bus.flush_active !== 1'b1) begin bad++; $display("[TB] FAIL b2b_flush: got %b expected 1", bus.flush_active); end
        total++; if (bus.imem_addr !== 32'h300) begin bad++; $display("[TB] FAIL b2b_pc: got %h expected 300", bus.imem_addr); end
        step(0, 0, 0, 0);
    endtask

    task automatic test_wrap_reset();
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc: got %h expected 0", bus.imem_addr); end
        total++; if (bus.ifid_instr !== 32'h00A0008F) begin bad++; $display("[TB] FAIL wrap_instr: got %h expected 00A0008F", bus.ifid_instr); end
        step(1, 0, 0, 0);
        bus.pc_hold = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.imem_addr !== 32'h0 || bus.ifid_pc !== 32'h0) begin bad++; $display("[TB] FAIL async_pc: got %h/%h expected 0/0", bus.imem_addr, bus.ifid_pc); end
        total++; if (bus.ifid_instr !== 32'h13 || bus.ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_ifid: got %h/%b expected 00000013/0", bus.ifid_instr, bus.ifid_valid); end
        total++; if ({bus.stall_active, bus.flush_active, bus.misalign_err, bus.stall_err} !== 4'b0) begin
            bad++; $display("[TB] FAIL async_status: got %b expected 0000", {bus.stall_active, bus.flush_active, bus.misalign_err, bus.stall_err});
        end
`ifdef FETCH_PERF_CNT_EN
        total++; if (bus.perf_stall_cycles !== 32'h0 || bus.perf_flushes !== 32'h0) begin
            bad++; $display("[TB] FAIL async_perf: got %0d/%0d expected 0/0", bus.perf_stall_cycles, bus.perf_flushes);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0);
        total++; if (bus.imem_addr !== 32'h4) begin bad++; $display("[TB] FAIL post_reset_pc: got %h expected 4", bus.imem_addr); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_free_run();
        test_bubble();
        test_branch_flush();
        test_misalign_stall_err();
        test_back_to_back();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_ifid_ctrl.md
Name: fetch_ifid_ctrl

Overview:
- Fetch-stage controller for the 5-stage RISC-V pipeline; the consumer side of the load-use hazard stall signals and the EX-stage branch redirect.
- Owns the PC register, drives the instruction-memory address, and owns the IF/ID pipeline register (pc, instr, valid).
- Applies hold and flush requests cycle-accurately.
- Static prediction is branch-not-taken; a taken branch squashes the wrong-path fetch.

Parameters:
- XLEN, 32, width of PC and branch target.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).
- MAX_STALL, 2, maximum consecutive hold cycles before stall_err sets.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_hold  in  1  1 = PC must not advance this cycle (hazard stall).
- ifid_hold  in  1  1 = IF/ID register must keep its contents this cycle.
- branch_taken  in  1  1 = EX resolved a taken branch/jump; redirect.
- branch_target  in  XLEN  redirect address; bits [1:0] ignored.
- imem_rdata  in  32  combinational instruction read of imem_addr.
- imem_addr  out  XLEN  current PC.
- ifid_pc  out  XLEN  PC of instruction held in IF/ID.
- ifid_instr  out  32  instruction held in IF/ID.
- ifid_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- stall_active  out  1  FSM in STALL.
- flush_active  out  1  FSM in FLUSH.
- misalign_err  out  1  one-cycle pulse: taken branch_target[1:0] != 0.
- stall_err  out  1  sticky: hold persisted longer than MAX_STALL cycles.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0.
  - FSM=RUN; all status outputs 0; stall counter 0.
- imem_addr = pc, combinational. IF/ID outputs are registered, so an instruction appears one cycle after its address.
- Effective hold: hold = pc_hold | ifid_hold. The PC never advances while IF/ID is held, so no fetch is lost.
- Per-edge priority (highest first):
  1. branch_taken=1:
     - pc <= {branch_target[XLEN-1:2],2'b00}.
     - ifid_instr <= NOP_INSTR; ifid_valid <= 0; ifid_pc <= 0.
     - FSM -> FLUSH.
     - misalign_err=1 next cycle if target[1:0] != 0.
     - Overrides any hold in the same cycle.
  2. ifid_hold=1: pc and IF/ID unchanged; FSM -> STALL.
  3. pc_hold=1, ifid_hold=0: pc unchanged; IF/ID loads bubble (NOP_INSTR, valid=0, ifid_pc=0); FSM -> STALL.
  4. Otherwise (advance): ifid_instr <= imem_rdata; ifid_pc <= pc; ifid_valid <= 1; pc <= pc+4; FSM -> RUN.
- PC arithmetic: modulo 2^XLEN; pc+4 from 32'hFFFF_FFFC wraps to 0 with no error.
- FSM states RUN, STALL, FLUSH; next state is set only by the priority above.
  - stall_active = (state==STALL).
  - flush_active = (state==FLUSH).
  - FLUSH lasts exactly one cycle unless branch_taken repeats.
- Stall counter (saturating, width clog2(MAX_STALL+2)):
  - Increments each cycle hold=1 and branch_taken=0; clears otherwise.
  - When counter > MAX_STALL: stall_err <= 1, held until reset.
- Reset mid-stall or mid-flush: returns to the reset values immediately; no pending redirect survives.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, two extra outputs:
  - perf_stall_cycles [31:0]: counts cycles with hold=1 and branch_taken=0.
  - perf_flushes [31:0]: counts cycles with branch_taken=1.
- Both counters are cleared by rst_n and wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then 4 free-running cycles with imem_rdata = 32'h00A00093 + pc -> imem_addr 0,4,8,12; ifid_pc lags by one cycle; ifid_valid=1 from cycle 2.
- Load-use hold: pc_hold=1 and ifid_hold=1 for 1 cycle at pc=8 -> pc stays 8, IF/ID unchanged, stall_active=1 for one cycle, then pc=12; stall_err=0.
- pc_hold=1, ifid_hold=0 at pc=16 -> ifid_instr=32'h00000013, ifid_valid=0, pc stays 16.
- branch_taken=1, target=32'h100, with pc_hold=1 in the same cycle -> pc=32'h100, ifid_valid=0, flush_active=1 for one cycle; then ifid_pc=32'h100.
- Target 32'h102 taken -> pc=32'h100, misalign_err one-cycle pulse; hold asserted 3 consecutive cycles (MAX_STALL=2) -> stall_err=1 and stays 1 until rst_n low.
- Wrap and reset: start at pc=32'hFFFF_FFFC, advance -> pc=0. Assert rst_n=0 asynchronously mid-stall -> all outputs return to reset values before the next edge; with FETCH_PERF_CNT_EN, counters read 0.
